// File: rtl/mat_mmu_pkg.sv
// mat_mmu_pkg: op codes, response status codes and FSM state encoding for mat_slot_allocator
package mat_mmu_pkg;
    typedef enum logic [1:0] {OP_ALLOC, OP_COUNT, OP_LOOKUP, OP_CLEAR} op_e;
    typedef enum logic [1:0] {ST_OK, ST_NOT_FOUND, ST_FULL, ST_BAD_ARG} status_e;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EXEC, S_RESP} state_e;
endpackage

// File: rtl/mat_shape_table.sv
// mat_shape_table: per-shape storage (m, n, base, count, wr_ptr) with one write port and a bulk clear
//   clk, rst_n     : clock, async active-low reset (clears every entry)
//   clear_i        : invalidate all entries
//   wr_*_i         : write one whole entry at wr_idx_i
//   rd_idx_i/rd_*_o: combinational read of one entry
module mat_shape_table #(
    parameter int MAX_TYPES = 4,
    parameter int DIM_W     = 5,
    parameter int ADDR_W    = 8,
    parameter int IW        = (MAX_TYPES > 1) ? $clog2(MAX_TYPES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [IW-1:0]     wr_idx_i,
    input  logic [DIM_W-1:0]  wr_m_i,
    input  logic [DIM_W-1:0]  wr_n_i,
    input  logic [ADDR_W-1:0] wr_base_i,
    input  logic [7:0]        wr_count_i,
    input  logic [7:0]        wr_ptr_i,
    input  logic [IW-1:0]     rd_idx_i,
    output logic              rd_valid_o,
    output logic [DIM_W-1:0]  rd_m_o,
    output logic [DIM_W-1:0]  rd_n_o,
    output logic [ADDR_W-1:0] rd_base_o,
    output logic [7:0]        rd_count_o,
    output logic [7:0]        rd_ptr_o
);
    logic [MAX_TYPES-1:0]             valid_q;
    logic [MAX_TYPES-1:0][DIM_W-1:0]  m_q, n_q;
    logic [MAX_TYPES-1:0][ADDR_W-1:0] base_q;
    logic [MAX_TYPES-1:0][7:0]        count_q, ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            m_q     <= '0;
            n_q     <= '0;
            base_q  <= '0;
            count_q <= '0;
            ptr_q   <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            m_q[wr_idx_i]     <= wr_m_i;
            n_q[wr_idx_i]     <= wr_n_i;
            base_q[wr_idx_i]  <= wr_base_i;
            count_q[wr_idx_i] <= wr_count_i;
            ptr_q[wr_idx_i]   <= wr_ptr_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_m_o     = m_q[rd_idx_i];
    assign rd_n_o     = n_q[rd_idx_i];
    assign rd_base_o  = base_q[rd_idx_i];
    assign rd_count_o = count_q[rd_idx_i];
    assign rd_ptr_o   = ptr_q[rd_idx_i];
endmodule

// File: rtl/mat_slot_allocator.sv
// mat_slot_allocator: per-shape slot allocator for matrix storage (ALLOC/COUNT/LOOKUP/CLEAR)
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : request handshake; req_op, req_m, req_n, req_id captured on accept
//   rsp_valid/rsp_ready        : response handshake; rsp_addr, rsp_count, rsp_status held until taken
//   used_types, free_ptr       : debug view of allocated shapes and next free word
module mat_slot_allocator
    import mat_mmu_pkg::*;
#(
    parameter int MAX_TYPES = 4,
    parameter int SLOTS     = 2,
    parameter int DIM_W     = 5,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DIM_W-1:0]  req_m,
    input  logic [DIM_W-1:0]  req_n,
    input  logic [7:0]        req_id,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [7:0]        rsp_count,
    output logic [1:0]        rsp_status,
    output logic [7:0]        used_types,
    output logic [ADDR_W:0]   free_ptr
);
    localparam int IW = (MAX_TYPES > 1) ? $clog2(MAX_TYPES) : 1;
    // wide enough that base + 8-bit multiplier * size never wraps before the range checks
    localparam int EW = 2 * DIM_W + ADDR_W + 10;

    state_e            state_q, state_d;
    op_e               op_q;
    logic [DIM_W-1:0]  m_q, n_q;
    logic [7:0]        id_q, used_types_q;
    logic [IW-1:0]     idx_q, hit_idx_q, rd_idx;
    logic              hit_q;
    logic [ADDR_W:0]   free_ptr_q;
    logic              rsp_valid_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [7:0]        rsp_count_q;
    status_e           rsp_status_q;

    logic              t_valid;
    logic [DIM_W-1:0]  t_m, t_n;
    logic [ADDR_W-1:0] t_base;
    logic [7:0]        t_count, t_ptr;

    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [ADDR_W-1:0] wr_base;
    logic [7:0]        wr_count, wr_ptr;
    logic [ADDR_W-1:0] res_addr;
    logic [7:0]        res_count;
    status_e           res_status;

    mat_shape_table #(.MAX_TYPES(MAX_TYPES), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .IW(IW)) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == S_EXEC && op_q == OP_CLEAR),
        .wr_en_i   (state_q == S_EXEC && wr_en),
        .wr_idx_i  (wr_idx),
        .wr_m_i    (m_q),
        .wr_n_i    (n_q),
        .wr_base_i (wr_base),
        .wr_count_i(wr_count),
        .wr_ptr_i  (wr_ptr),
        .rd_idx_i  (rd_idx),
        .rd_valid_o(t_valid),
        .rd_m_o    (t_m),
        .rd_n_o    (t_n),
        .rd_base_o (t_base),
        .rd_count_o(t_count),
        .rd_ptr_o  (t_ptr)
    );

    logic [EW-1:0]     size, reserve;
    logic [ADDR_W-1:0] slot_addr, lk_addr;
    logic [ADDR_W:0]   fp_next;
    logic              bad, match, new_type;

    assign size      = EW'(m_q) * EW'(n_q);
    assign reserve   = EW'(SLOTS) * size;
    assign fp_next   = (ADDR_W+1)'(EW'(free_ptr_q) + reserve);
    assign slot_addr = ADDR_W'(EW'(t_base) + EW'(t_ptr) * size);
    assign lk_addr   = ADDR_W'(EW'(t_base) + (EW'(id_q) - EW'(1)) * size);
    assign bad       = op_q != OP_CLEAR && (m_q == '0 || n_q == '0);
    assign match     = t_valid && t_m == m_q && t_n == n_q;
    assign new_type  = op_q == OP_ALLOC && !bad && !hit_q && used_types_q < 8'(MAX_TYPES)
                       && EW'(free_ptr_q) + reserve <= EW'(MEM_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = req_valid ? S_SCAN : S_IDLE;
            S_SCAN: state_d = (idx_q == IW'(MAX_TYPES - 1)) ? S_EXEC : S_SCAN;
            S_EXEC: state_d = S_RESP;
            S_RESP: state_d = (rsp_valid_q && rsp_ready) ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = state_q == S_IDLE;
        rd_idx    = (state_q == S_SCAN) ? idx_q : hit_idx_q;
    end

    // EXEC result: what to answer and what (if anything) to write back to the table
    always_comb begin
        res_status = ST_OK;
        res_addr   = '0;
        res_count  = '0;
        wr_en      = 1'b0;
        wr_idx     = hit_idx_q;
        wr_base    = t_base;
        wr_count   = (t_count >= 8'(SLOTS)) ? 8'(SLOTS) : t_count + 8'd1;
        wr_ptr     = (t_ptr == 8'(SLOTS - 1)) ? 8'd0 : t_ptr + 8'd1;
        if (op_q == OP_CLEAR) begin
            res_status = ST_OK;
        end else if (bad) begin
            res_status = ST_BAD_ARG;
        end else if (op_q == OP_ALLOC && hit_q) begin
            wr_en     = 1'b1;
            res_addr  = slot_addr;
            res_count = wr_count;
        end else if (op_q == OP_ALLOC && new_type) begin
            wr_en     = 1'b1;
            wr_idx    = IW'(used_types_q);
            wr_base   = ADDR_W'(free_ptr_q);
            wr_count  = 8'd1;
            wr_ptr    = 8'(1 % SLOTS);
            res_addr  = ADDR_W'(free_ptr_q);
            res_count = 8'd1;
        end else if (op_q == OP_ALLOC) begin
            res_status = ST_FULL;
        end else if (!hit_q) begin
            res_status = ST_NOT_FOUND;
        end else if (op_q == OP_COUNT) begin
            res_addr  = t_base;
            res_count = t_count;
        end else if (id_q != 8'd0 && id_q <= t_count) begin
            res_addr  = lk_addr;
            res_count = t_count;
        end else begin
            res_status = ST_BAD_ARG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= OP_ALLOC;
            m_q          <= '0;
            n_q          <= '0;
            id_q         <= '0;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            free_ptr_q   <= '0;
            used_types_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_addr_q   <= '0;
            rsp_count_q  <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            if (req_valid && req_ready) begin
                op_q  <= op_e'(req_op);
                m_q   <= req_m;
                n_q   <= req_n;
                id_q  <= req_id;
                idx_q <= '0;
                hit_q <= 1'b0;
            end
            if (state_q == S_SCAN) begin
                idx_q <= idx_q + IW'(1);
                if (match && !hit_q) begin
                    hit_q     <= 1'b1;
                    hit_idx_q <= idx_q;
                end
            end
            if (state_q == S_EXEC) begin
                rsp_addr_q   <= res_addr;
                rsp_count_q  <= res_count;
                rsp_status_q <= res_status;
                if (op_q == OP_CLEAR) begin
                    free_ptr_q   <= '0;
                    used_types_q <= '0;
                end else if (new_type) begin
                    free_ptr_q   <= fp_next;
                    used_types_q <= used_types_q + 8'd1;
                end
            end
            // valid rises one cycle into RESP and drops on the accepting edge
            rsp_valid_q <= state_q == S_RESP && !(rsp_valid_q && rsp_ready);
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_addr   = rsp_addr_q;
    assign rsp_count  = rsp_count_q;
    assign rsp_status = rsp_status_q;
    assign used_types = used_types_q;
    assign free_ptr   = free_ptr_q;
endmodule
